// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin front end that shares one GCD custom-instruction
// core among NREQ requesters. One job is in flight at a time. A watchdog
// aborts jobs the core never finishes and reports them with rsp_err.
module gcd_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 core_clk_en,
  output logic                 core_start,
  output logic [31:0]          core_dataa,
  output logic [31:0]          core_datab,
  input  logic                 core_done,
  input  logic [31:0]          core_result
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_reg;
  logic [2:0]        rr_ptr_reg;
  logic [2:0]        grant_reg;
  logic [CW-1:0]     wait_cnt_reg;
  logic [31:0]       op_a_reg;
  logic [31:0]       op_b_reg;
  logic [31:0]       rsp_data_reg;
  logic              rsp_err_reg;
  logic [NREQ-1:0]   rsp_valid_reg;
  logic              core_start_reg;

  // Arbitration results for the current IDLE cycle.
  logic              grant_found;
  logic [2:0]        grant_next;
  logic              accept;
  logic [31:0]       sel_a;
  logic [31:0]       sel_b;
  logic [NREQ-1:0]   owner_onehot;

  // Unpacked view of the per-requester operand slices.
  logic [31:0]       a_slice [NREQ];
  logic [31:0]       b_slice [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign a_slice[gi]      = req_a[32*gi +: 32];
      assign b_slice[gi]      = req_b[32*gi +: 32];
      // The accept strobe only exists in IDLE, and never while reset is held.
      assign req_ready[gi]    = accept && (grant_next == 3'(gi));
      assign owner_onehot[gi] = (grant_reg == 3'(gi));
    end
  endgenerate

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_next  = rr_ptr_reg;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!grant_found && (j == (int'(rr_ptr_reg) + k) % NREQ) && req_valid[j]) begin
          grant_found = 1'b1;
          grant_next  = 3'(j);
        end
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_a = 32'd0;
    sel_b = 32'd0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant_next == 3'(j)) begin
        sel_a = a_slice[j];
        sel_b = b_slice[j];
      end
    end
  end

  assign accept = (state_reg == IDLE) && grant_found && !reset;

  // Job sequencer: accept, issue to the core, wait with watchdog, respond.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= 3'd0;
      grant_reg      <= 3'd0;
      wait_cnt_reg   <= '0;
      op_a_reg       <= 32'd0;
      op_b_reg       <= 32'd0;
      rsp_data_reg   <= 32'd0;
      rsp_err_reg    <= 1'b0;
      rsp_valid_reg  <= '0;
      core_start_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_a_reg       <= sel_a;
            op_b_reg       <= sel_b;
            grant_reg      <= grant_next;
            core_start_reg <= 1'b1;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          core_start_reg <= 1'b0;
          wait_cnt_reg   <= '0;
          state_reg      <= WAIT;
        end
        WAIT: begin
          // A done arriving on the timeout cycle still counts as success.
          if (core_done) begin
            rsp_data_reg  <= core_result;
            rsp_err_reg   <= 1'b0;
            rsp_valid_reg <= owner_onehot;
            state_reg     <= RESP;
          end else if (wait_cnt_reg == CW'(TIMEOUT)) begin
            rsp_data_reg  <= 32'd0;
            rsp_err_reg   <= 1'b1;
            rsp_valid_reg <= owner_onehot;
            state_reg     <= RESP;
          end else begin
            wait_cnt_reg  <= wait_cnt_reg + 1'b1;
          end
        end
        RESP: begin
          rsp_valid_reg <= '0;
          rr_ptr_reg    <= (grant_reg == 3'(NREQ - 1)) ? 3'd0 : grant_reg + 3'd1;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_reg;
  assign rsp_data    = rsp_data_reg;
  assign rsp_err     = rsp_err_reg;
  assign busy        = (state_reg != IDLE);
  assign grant_id    = grant_reg;
  assign core_clk_en = !reset;
  assign core_start  = core_start_reg;
  assign core_dataa  = op_a_reg;
  assign core_datab  = op_b_reg;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Self-checking bench for gcd_arbiter: behavioural GCD core stub, a table of
// directed jobs, hand-written reset/spurious-done sequences and a randomized
// round-robin phase checked against an arithmetic reference model.
module tb_gcd_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [32*NREQ-1:0]  req_a = '0;
  logic [32*NREQ-1:0]  req_b = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     rsp_valid;
  logic [31:0]         rsp_data;
  logic                rsp_err;
  logic                busy;
  logic [2:0]          grant_id;
  logic                core_clk_en;
  logic                core_start;
  logic [31:0]         core_dataa;
  logic [31:0]         core_datab;
  logic                core_done;
  logic [31:0]         core_result;

  gcd_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .grant_id(grant_id),
    .core_clk_en(core_clk_en), .core_start(core_start),
    .core_dataa(core_dataa), .core_datab(core_datab),
    .core_done(core_done), .core_result(core_result)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic: Euclid's algorithm and its modulo step count.
  function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  function automatic int gcd_k(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    int k = 0;
    while (b != 0) begin t = a % b; a = b; b = t; k++; end
    return k;
  endfunction

  // Core stub: done pulse K+2 cycles after start; restart on every start.
  logic        mute = 1'b0;
  logic        spur_done = 1'b0;
  logic        stub_done = 1'b0;
  logic [31:0] stub_res = 32'd0;
  int          stub_cnt = 0;
  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (core_start) begin
      stub_res <= gcd_ref(core_dataa, core_datab);
      stub_cnt <= mute ? 0 : gcd_k(core_dataa, core_datab) + 1;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_done <= 1'b1;
    end
  end
  assign core_done   = stub_done | spur_done;
  assign core_result = stub_res;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_accept(output int t0);
    int n = 0;
    t0 = -1;
    while (n < 50) begin
      if (req_ready != 0) begin t0 = cyc; break; end
      @(negedge clk); #1;
      n++;
    end
    if (t0 < 0) begin
      tests++; fails++;
      $display("FAIL accept_wait: got no req_ready expected one within 50 cycles");
    end
  endtask

  task automatic wait_rsp(input int t0, output int lat);
    int n = 0;
    lat = -1;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (rsp_valid != 0) begin lat = cyc - t0; break; end
    end
    if (lat < 0) begin
      tests++; fails++;
      $display("FAIL rsp_wait: got no rsp_valid expected one within 100 cycles");
    end
  endtask

  // One job from a single requester; caller is just past a negedge in IDLE.
  task automatic run_job(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic mute_i, input logic [31:0] exp_d,
                         input logic exp_e, input int exp_lat);
    int t0, lat;
    req_a[32*idx +: 32] = a;
    req_b[32*idx +: 32] = b;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    mute = mute_i;
    #1;
    wait_accept(t0);
    check("req_ready", 32'(req_ready), 32'(1 << idx));
    @(negedge clk);
    req_valid = '0;
    check("core_start", 32'(core_start), 32'd1);
    check("core_dataa", core_dataa, a);
    check("core_datab", core_datab, b);
    check("grant_id", 32'(grant_id), 32'(idx));
    check("busy", 32'(busy), 32'd1);
    wait_rsp(t0, lat);
    check("rsp_valid", 32'(rsp_valid), 32'(1 << idx));
    check("rsp_data", rsp_data, exp_d);
    check("rsp_err", 32'(rsp_err), 32'(exp_e));
    check("latency", 32'(lat), 32'(exp_lat));
    $display("[TB] job req%0d (%0d,%0d) -> data=%0d err=%0d lat=%0d",
             idx, a, b, rsp_data, rsp_err, lat);
    mute = 1'b0;
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic        mute;
    logic [31:0] d;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #1000000;
    $display("FAIL global_watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, lat, g, ptr, seen;
    logic [31:0] ra [NREQ];
    logic [31:0] rb [NREQ];
    logic [NREQ-1:0] mask;

    vecs[0] = '{0, 48, 18, 1'b0, 6, 1'b0, 7};       // single job, K=3
    vecs[1] = '{2, 0, 0, 1'b0, 0, 1'b0, 4};         // minimum round trip
    vecs[2] = '{2, 0, 35, 1'b0, 35, 1'b0, 5};
    vecs[3] = '{2, 21, 0, 1'b0, 21, 1'b0, 4};
    vecs[4] = '{1, 5, 5, 1'b1, 0, 1'b1, TIMEOUT + 3}; // silent core
    vecs[5] = '{3, 1071, 462, 1'b0, 21, 1'b0, 7};   // normal job after timeout
    vecs[6] = '{0, 987, 610, 1'b0, 1, 1'b0, 18};    // done on the timeout cycle
    vecs[7] = '{1, 1597, 987, 1'b0, 0, 1'b1, 18};   // done one cycle too late
    vecs[8] = '{3, 100, 75, 1'b0, 25, 1'b0, 6};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_core_start", 32'(core_start), 0);
    check("rst_core_clk_en", 32'(core_clk_en), 0);
    check("rst_core_dataa", core_dataa, 0);
    check("rst_core_datab", core_datab, 0);
    check("rst_grant_id", 32'(grant_id), 0);
    reset = 1'b0;
    #1;
    check("clk_en_after_reset", 32'(core_clk_en), 1);
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      run_job(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].mute,
              vecs[i].d, vecs[i].e, vecs[i].lat);
      @(negedge clk);
    end

    // Spurious done in IDLE and in the cycle after RESP.
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid != 0 || busy) seen++;
    end
    check("spurious_idle", 32'(seen), 0);
    run_job(0, 9, 6, 1'b0, 3, 1'b0, 6);
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid != 0 || busy) seen++;
    end
    check("spurious_after_resp", 32'(seen), 0);

    // Reset mid-WAIT: rr_ptr was moved to 3 by a job on requester 2.
    run_job(2, 9, 6, 1'b0, 3, 1'b0, 6);
    @(negedge clk);
    req_a[32 +: 32] = 1071;
    req_b[32 +: 32] = 462;
    req_valid = 4'b0010;
    #1;
    wait_accept(t0);
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("busy_after_mid_reset", 32'(busy), 0);
    check("grant_after_mid_reset", 32'(grant_id), 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid != 0 || busy) seen++;
    end
    check("no_rsp_after_reset", 32'(seen), 0);
    // With rr_ptr back at 0, requester 1 beats requester 3.
    req_a[96 +: 32] = 10;
    req_b[96 +: 32] = 4;
    req_valid = 4'b1010;
    #1;
    wait_accept(t0);
    check("rr_ptr_reset_grant", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(t0, lat);
    check("mid_reset_rsp_valid", 32'(rsp_valid), 32'b0010);
    check("mid_reset_rsp_data", rsp_data, 21);
    $display("[TB] job req1 (1071,462) after reset -> data=%0d lat=%0d", rsp_data, lat);

    // Round-robin with all requesters holding valid from reset.
    reset = 1'b1;
    ra[0] = 12;  rb[0] = 8;
    ra[1] = 35;  rb[1] = 21;
    ra[2] = 81;  rb[2] = 27;
    ra[3] = 100; rb[3] = 45;
    for (int j = 0; j < NREQ; j++) begin
      req_a[32*j +: 32] = ra[j];
      req_b[32*j +: 32] = rb[j];
    end
    req_valid = '1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int j = 0; j < 5; j++) begin
      wait_accept(t0);
      check("rr_grant", 32'(req_ready), 32'(1 << (j % NREQ)));
      wait_rsp(t0, lat);
      check("rr_rsp_owner", 32'(rsp_valid), 32'(1 << (j % NREQ)));
      check("rr_rsp_data", rsp_data, gcd_ref(ra[j % NREQ], rb[j % NREQ]));
      $display("[TB] rr job %0d owner=%b data=%0d", j, rsp_valid, rsp_data);
      @(negedge clk);
      #1;
    end
    req_valid = '0;

    // Randomized phase against the reference model.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ptr = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int j = 0; j < NREQ; j++) begin
        ra[j] = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(0, 4095));
        rb[j] = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(0, 4095));
        req_a[32*j +: 32] = ra[j];
        req_b[32*j +: 32] = rb[j];
      end
      req_valid = mask;
      #1;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && mask[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
      end
      check("rand_grant", 32'(req_ready), 32'(1 << g));
      t0 = cyc;
      @(negedge clk);
      req_valid = '0;
      wait_rsp(t0, lat);
      check("rand_owner", 32'(rsp_valid), 32'(1 << g));
      if (gcd_k(ra[g], rb[g]) + 1 > TIMEOUT) begin
        check("rand_err", 32'(rsp_err), 1);
        check("rand_data", rsp_data, 0);
        check("rand_lat", 32'(lat), 32'(TIMEOUT + 3));
      end else begin
        check("rand_err", 32'(rsp_err), 0);
        check("rand_data", rsp_data, gcd_ref(ra[g], rb[g]));
        check("rand_lat", 32'(lat), 32'(4 + gcd_k(ra[g], rb[g])));
      end
      $display("[TB] rand job %0d req%0d (%0d,%0d) -> data=%0d err=%0d lat=%0d",
               n, g, ra[g], rb[g], rsp_data, rsp_err, lat);
      ptr = (g + 1) % NREQ;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gcd_arbiter.md
# gcd_arbiter

Round-robin arbiter and sequencer that shares one GCD custom-instruction core among NREQ requesters. Each requester hands over an operand pair through a valid/ready handshake. The arbiter issues the pair to the core and waits for the core's done pulse, then returns the result to the owning requester with a one-cycle response pulse. A watchdog aborts a job the core never completes and flags it as an error.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 1023, maximum WAIT cycles before a job is aborted (≥ 2)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  requester i has an operand pair pending
- req_a  in  32*NREQ  operand A; requester i uses bits [32i+31:32i]
- req_b  in  32*NREQ  operand B; same packing as req_a
- req_ready  out  NREQ  one-hot accept strobe
- rsp_valid  out  NREQ  one-hot, one-cycle response pulse to the owning requester
- rsp_data  out  32  GCD result, meaningful while any rsp_valid bit is high
- rsp_err  out  1  qualifies rsp_valid; 1 = timeout, rsp_data = 0
- busy  out  1  high in every state except IDLE
- grant_id  out  3  index of the current owner; holds the last owner while in IDLE
- core_clk_en  out  1  clock enable to the core
- core_start  out  1  one-cycle start to the core
- core_dataa  out  32  operand A to the core
- core_datab  out  32  operand B to the core
- core_done  in  1  one-cycle done pulse from the core
- core_result  in  32  result from the core; valid when core_done = 1

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Search starts at rr_ptr and wraps modulo NREQ; the first i with req_valid[i] = 1 is the grant g.
  - req_ready[g] = 1 combinationally in that same cycle; this is the accept.
  - On accept: latch req_a/req_b slice g into op_a/op_b, set grant_id = g, go to ISSUE.
  - No request pending: stay in IDLE.
- **ISSUE**: core_start = 1, core_dataa = op_a, core_datab = op_b; clear wait counter; go to WAIT.
- **WAIT**
  - Counter increments every cycle.
  - core_done = 1: capture core_result into rsp_data, rsp_err = 0, go to RESP.
  - Counter reaches TIMEOUT with no done: rsp_data = 0, rsp_err = 1, go to RESP.
  - core_done and timeout in the same cycle: done wins.
- **RESP**: rsp_valid[grant_id] = 1 for one cycle; rr_ptr = (grant_id + 1) mod NREQ; go to IDLE.
- core_clk_en = 1 in every cycle except while reset is asserted.
- core_dataa/core_datab hold op_a/op_b outside ISSUE.
- core_done is ignored outside WAIT. A late done after a timeout is discarded, and the next core_start restarts the core.
- The response channel has no backpressure; the requester samples on the pulse.
- Dropping req_valid before accept is legal and has no effect. Operands are sampled only at accept.
- Only one job is in flight at a time. Requests that are not accepted stay pending with no ordering guarantee beyond round-robin.

## Timing
- Reset values: state IDLE; rr_ptr 0; grant_id 0.
  - req_ready, rsp_valid, rsp_err, busy, core_start, core_clk_en: all 0.
  - rsp_data, core_dataa, core_datab: 0.
- Accept at cycle t → core_start at t+1.
- Core with K modulo steps → core_done at t+3+K, rsp_valid at t+4+K.
- Minimum round trip, operand 0 (K = 0): rsp_valid at t+4.
- Next accept is no earlier than the cycle after RESP.
- Timeout → rsp_valid with rsp_err at t+TIMEOUT+3.
- Reset asserted in any state:
  - FSM returns to IDLE next cycle.
  - No rsp_valid is produced for the aborted job.
  - core_start stays 0.
  - Any later core_done is ignored.

## Test plan
- **Single job.** Req0 sends (48,18), accepted at t → core_start at t+1; rsp_valid[0] at t+7 with rsp_data = 6 and rsp_err = 0.
- **Zero operands.** Req2 sends (0,0) → rsp_data = 0 at t+4. Req2 then sends (0,35) → 35. Req2 then sends (21,0) → 21.
- **Round-robin.** All four requesters hold valid from reset with distinct pairs → grant order 0,1,2,3,0. Each rsp_valid goes only to its owner, with the correct GCD.
- **Timeout.** TIMEOUT = 15 and a stub core that never asserts done. Req1 accepted at t → rsp_valid[1] at t+18 with rsp_err = 1 and rsp_data = 0. The next job then completes normally.
- **Reset mid-WAIT.** Reset pulses during WAIT of (1071,462) → no rsp_valid follows; busy = 0 and rr_ptr = 0 after reset. A new (1071,462) returns 21.
- **Spurious done.** core_done pulsed while in IDLE and again one cycle after RESP → no rsp_valid and no state change.
